// File: rtl/tp_fifo_ctrl.sv
// Single-clock FIFO controller in front of a 1-cycle-latency SRAM macro.
// A 2-entry prefetch buffer makes the pop side first-word-fall-through.
module tp_fifo_ctrl #(
  parameter int MEM_DEPTH  = 12,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   fifo_cnt,
  output logic                  mem_ceab,
  output logic                  mem_weab,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [DATA_WIDTH-1:0] mem_bwab,
  output logic                  mem_cebb,
  output logic                  mem_rebb,
  output logic [ADDR_WIDTH-1:0] mem_addrb,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   sram_cnt;
  logic                  inflight;
  logic [1:0]            buf_cnt, nxt_cnt;
  logic [DATA_WIDTH-1:0] head_q, tail_q, nxt_head, nxt_tail;
  logic [1:0]            occ;
  logic                  push, pop, issue;

  assign wr_ready = (sram_cnt < DEPTH);
  assign push     = wr_valid & wr_ready & rst_n;
  assign rd_valid = (buf_cnt != 2'd0);
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = head_q;

  // Slots already committed to the buffer after this cycle's pop; never exceeds 2.
  assign occ   = buf_cnt + 2'(inflight) - 2'(pop);
  assign issue = (sram_cnt != '0) && (occ < 2'd2);

  assign fifo_cnt = sram_cnt + (ADDR_WIDTH + 1)'(inflight) + (ADDR_WIDTH + 1)'(buf_cnt);

  assign mem_ceab  = ~push;
  assign mem_weab  = ~push;
  assign mem_addra = wptr;
  assign mem_din   = wr_data;
  assign mem_bwab  = '0;
  assign mem_cebb  = ~issue;
  assign mem_rebb  = ~issue;
  assign mem_addrb = rptr;

  // Pop shifts first, then the returning SRAM word lands in the first free slot.
  always_comb begin
    nxt_cnt  = buf_cnt;
    nxt_head = head_q;
    nxt_tail = tail_q;
    if (pop) begin
      nxt_head = tail_q;
      nxt_cnt  = buf_cnt - 2'd1;
    end
    if (inflight) begin
      if (nxt_cnt == 2'd0) begin
        nxt_head = mem_dout;
      end else begin
        nxt_tail = mem_dout;
      end
      nxt_cnt = nxt_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
      end
      if (issue) begin
        rptr <= (rptr == LAST_ADDR) ? '0 : rptr + 1'b1;
      end
      sram_cnt <= sram_cnt + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(issue);
      inflight <= issue;
      buf_cnt  <= nxt_cnt;
      head_q   <= nxt_head;
      tail_q   <= nxt_tail;
    end
  end

endmodule

// File: tb/tb_tp_fifo_ctrl.sv
// Bench for tp_fifo_ctrl: behavioural SRAM, item-queue reference model and
// a scoreboard of accepted words checked whenever the DUT pops.
module tb_tp_fifo_ctrl;

  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int DW    = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DW-1:0] wr_data, rd_data, mem_din, mem_bwab, mem_dout;
  logic [AW:0]   fifo_cnt;
  logic          mem_ceab, mem_weab, mem_cebb, mem_rebb;
  logic [AW-1:0] mem_addra, mem_addrb;

  tp_fifo_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .fifo_cnt(fifo_cnt),
    .mem_ceab(mem_ceab), .mem_weab(mem_weab), .mem_addra(mem_addra),
    .mem_din(mem_din), .mem_bwab(mem_bwab),
    .mem_cebb(mem_cebb), .mem_rebb(mem_rebb), .mem_addrb(mem_addrb),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // SRAM macro: registered read, one cycle latency.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!mem_ceab && !mem_weab) sram[mem_addra] <= mem_din;
    if (!mem_cebb && !mem_rebb) mem_dout <= sram[mem_addrb];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted word in order; the first m_buf sit in the
  // prefetch buffer, the next m_fly are being read, the rest are in SRAM.
  logic [DW-1:0] sb_q[$];
  int m_sram = 0, m_fly = 0, m_buf = 0, m_waddr = 0, m_raddr = 0;
  int dut_acc = 0, dut_iss = 0;

  initial begin
    bit e_wr, e_pop, e_push, e_iss;
    logic [DW-1:0] exp_d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        chk("rst_cebb", mem_cebb, 1);
        chk("rst_addrb", mem_addrb, 0);
        chk("rst_addra", mem_addra, 0);
        m_sram = 0; m_fly = 0; m_buf = 0; m_waddr = 0; m_raddr = 0;
        sb_q.delete();
      end else begin
        e_wr   = (m_sram < DEPTH);
        e_pop  = (m_buf > 0) && rd_ready;
        e_push = wr_valid && e_wr;
        e_iss  = (m_sram > 0) && (m_buf + m_fly - int'(e_pop) < 2);
        chk("wr_ready", wr_ready, int'(e_wr));
        chk("rd_valid", rd_valid, int'(m_buf > 0));
        chk("fifo_cnt", fifo_cnt, m_sram + m_fly + m_buf);
        chk("mem_ceab", mem_ceab, int'(!e_push));
        chk("mem_weab", mem_weab, int'(!e_push));
        chk("mem_cebb", mem_cebb, int'(!e_iss));
        chk("mem_rebb", mem_rebb, int'(!e_iss));
        chk("mem_bwab", mem_bwab, 0);
        if (e_push) begin
          chk("mem_addra", mem_addra, m_waddr);
          chk("mem_din", mem_din, wr_data);
        end
        if (e_iss) chk("mem_addrb", mem_addrb, m_raddr);
        if (wr_valid && wr_ready) dut_acc++;
        if (!mem_cebb) dut_iss++;
        if (rd_valid) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_rd_valid", 1, 0);
          end else if (rd_ready) begin
            exp_d = sb_q.pop_front();
            chk("pop_data", rd_data, exp_d);
          end else begin
            chk("hold_data", rd_data, sb_q[0]);
          end
        end else if (e_pop) begin
          // Model popped but the DUT did not present a word; keep in step.
          void'(sb_q.pop_front());
        end
        m_buf  = m_buf - int'(e_pop) + m_fly;
        m_fly  = int'(e_iss);
        m_sram = m_sram + int'(e_push) - int'(e_iss);
        if (e_push) m_waddr = (m_waddr + 1) % DEPTH;
        if (e_iss)  m_raddr = (m_raddr + 1) % DEPTH;
      end
    end
  end

  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr,
                      output bit acc);
    @(posedge clk); #1;
    wr_valid = wv; wr_data = wd; rd_ready = rr;
    acc = wv && rst_n && (m_sram < DEPTH);
    if (acc) sb_q.push_back(wd);
  endtask

  task automatic idle(input logic rr, input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, rr, a);
  endtask

  task automatic drain();
    int n = 0;
    bit a;
    while (sb_q.size() != 0 && n < 200) begin
      step(1'b0, '0, 1'b1, a);
      n++;
    end
    idle(1'b1, 2);
    chk("drain_left", sb_q.size(), 0);
    chk("drain_empty", rd_valid, 0);
  endtask

  initial begin
    bit a;
    int acc0, iss0, got;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single word, fall-through latency
    step(1'b1, 10'h155, 1'b0, a);
    idle(1'b0, 4);
    drain();

    // Backpressure fill to MEM_DEPTH+2
    acc0 = dut_acc;
    for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0, a);
    idle(1'b0, 1);
    @(negedge clk); #1;
    chk("bp_accepts", dut_acc - acc0, DEPTH + 2);
    chk("bp_fifo_cnt", fifo_cnt, DEPTH + 2);
    chk("bp_wr_ready", wr_ready, 0);
    drain();

    // Streaming
    for (int i = 0; i < 100; i++) step(1'b1, DW'(i + 32), 1'b1, a);
    drain();

    // Wrap-around with toggling rd_ready
    got = 0;
    for (int i = 0; i < 200 && got < 30; i++) begin
      step(1'b1, DW'($urandom), 1'(i % 2), a);
      if (a) got++;
    end
    chk("wrap_words", got, 30);
    drain();

    // Buffer hold: only two reads may be issued while stalled
    iss0 = dut_iss;
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b0, a);
    idle(1'b0, 10);
    @(negedge clk); #1;
    chk("hold_issues", dut_iss - iss0, 2);
    chk("hold_head", rd_data, 1);
    drain();

    // Reset with entries stored and a read in flight
    for (int i = 0; i < 8; i++) step(1'b1, DW'(i + 100), 1'b0, a);
    idle(1'b0, 2);
    idle(1'b1, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_fifo_cnt", fifo_cnt, 0);
    chk("midrst_wr_ready", wr_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    step(1'b1, 10'h2AA, 1'b0, a);
    idle(1'b0, 4);
    chk("post_rst_head", rd_data, 10'h2AA);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 2) != 0), a);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tp_fifo_ctrl.md
Name: tp_fifo_ctrl

Overview:
Synchronous single-clock FIFO controller that owns one tp_sram instance. Both SRAM clocks tie to clk. The controller drives the SRAM write port from a valid/ready push interface. It hides the SRAM's 1-cycle registered read latency behind a 2-entry prefetch buffer, so the pop side is first-word-fall-through valid/ready. It sits directly upstream of the SRAM macro in the FIFO/sram_wrapper hierarchy and serves as the standard FIFO front-end for the sync_aggr datapath.

Parameters:
MEM_DEPTH, 12, number of SRAM entries; any value 2..2^ADDR_WIDTH, non-power-of-two allowed
ADDR_WIDTH, 4, SRAM address width
DATA_WIDTH, 10, payload width

Ports:
clk  input  1  single clock; also drives SRAM clka and clkb
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  push request
wr_ready  output  1  push accepted when wr_valid & wr_ready
wr_data  input  DATA_WIDTH  push payload
rd_valid  output  1  rd_data holds the oldest entry
rd_ready  input  1  pop when rd_valid & rd_ready
rd_data  output  DATA_WIDTH  head of FIFO
fifo_cnt  output  ADDR_WIDTH+1  total entries held (SRAM + in-flight + buffer)
mem_ceab  output  1  SRAM write chip enable, active low
mem_weab  output  1  SRAM write enable, active low
mem_addra  output  ADDR_WIDTH  SRAM write address
mem_din  output  DATA_WIDTH  SRAM write data (= wr_data)
mem_bwab  output  DATA_WIDTH  SRAM bit-write mask, active low; tied all-zero (full-word writes)
mem_cebb  output  1  SRAM read chip enable, active low
mem_rebb  output  1  SRAM read enable, active low; equals mem_cebb
mem_addrb  output  ADDR_WIDTH  SRAM read address
mem_dout  input  DATA_WIDTH  SRAM read data; valid the cycle after a read is issued

Behaviour:
- Reset (async assert, sync release): wptr=0, rptr=0, sram_cnt=0, buffer empty, inflight=0.
- Outputs in reset: wr_ready=1, rd_valid=0, rd_data=0, fifo_cnt=0, mem_ceab/weab/cebb/rebb=1, mem_addra=mem_addrb=0.
- Write: push = wr_valid & wr_ready.
  - wr_ready = (sram_cnt < MEM_DEPTH), taken from the registered count only. A same-cycle pop never frees space for a push.
  - On push, mem_ceab=mem_weab=0 and mem_addra=wptr.
  - wptr increments; after MEM_DEPTH-1 it wraps to 0.
- Read issue: a read is issued when sram_cnt>0 and (buf_cnt + inflight - pop) < 2.
  - On issue, mem_cebb=mem_rebb=0 and mem_addrb=rptr.
  - rptr increments with the same wrap rule as wptr.
  - sram_cnt decrements on issue; inflight is set for 1 cycle.
  - The read uses only the registered sram_cnt, so the SRAM is never read at an address being written that same cycle.
- Capture: in the cycle after an issue, mem_dout is written into the buffer tail at the clock edge.
- Buffer: 2-entry register FIFO.
  - rd_valid = (buf_cnt>0); rd_data = buffer head.
  - Pop and capture in the same cycle are both honoured; order is preserved.
  - rd_data holds its value while rd_valid & !rd_ready.
- Counters:
  - sram_cnt(next) = sram_cnt + push - issue.
  - fifo_cnt = sram_cnt + inflight + buf_cnt; maximum MEM_DEPTH+2.
- Latency: a push in cycle N gives read issue in N+1, capture at the end of N+2, and rd_valid=1 in N+3.
- Throughput: with rd_ready held at 1, one push and one pop per cycle are sustained indefinitely.
- Backpressure: with rd_ready=0, up to 2 entries drain into the buffer.
  - The SRAM then fills to MEM_DEPTH and wr_ready falls.
  - Maximum occupancy is MEM_DEPTH+2.
- Empty: no read is issued, mem_cebb=1, and rd_valid falls once the buffer drains.
- Mid-operation reset: every pointer, count and buffer entry clears immediately. Any in-flight mem_dout is discarded. SRAM contents are not cleared.
- Illegal input: a push while wr_ready=0 or a pop while rd_valid=0 is ignored, with no state change.

Test Plan:
- Reset, then a single push of 0x155 in cycle 0 -> mem_weab=0 at addr 0 in cycle 0; mem_cebb=0 at addr 0 in cycle 1; rd_valid=1 with rd_data=0x155 in cycle 3; fifo_cnt=1 from cycle 1 until popped.
- rd_ready=0 and 16 consecutive pushes of 1..16 -> 14 pushes accepted; wr_ready=0 after the 14th; fifo_cnt=14; then pop all with rd_ready=1 -> data 1..14 in order, rd_valid=0 after the 14th pop.
- Continuous push and pop of 100 incrementing words with rd_ready=1 -> after the initial 3-cycle latency, one word per cycle, no gaps, no loss; fifo_cnt steady at 3.
- Wrap-around: 30 words through the FIFO with rd_ready toggling every other cycle -> mem_addra and mem_addrb sequence 0..11,0..; output data in order.
- Buffer hold: fill 5 words, hold rd_ready=0 for 10 cycles -> rd_data stable at word 1; exactly 2 reads issued, then mem_cebb=1.
- Assert rst_n=0 with 8 entries stored and a read in flight -> same cycle: rd_valid=0, fifo_cnt=0, wr_ready=1; after release, a new push of 0x2AA is read back as the first word.
